// File: rtl/z3_bus_master_pkg.sv
// rtl/z3_bus_master_pkg.sv - state encodings and 68030 SIZ codes for the Zorro III bus master
package z3_bus_master_pkg;

   localparam logic [2:0] Z3M_IDLE      = 3'd0;
   localparam logic [2:0] Z3M_REQUEST   = 3'd1;
   localparam logic [2:0] Z3M_OWN       = 3'd2;
   localparam logic [2:0] Z3M_ADDR      = 3'd3;
   localparam logic [2:0] Z3M_STROBE    = 3'd4;
   localparam logic [2:0] Z3M_DATA_WAIT = 3'd5;
   localparam logic [2:0] Z3M_TERM      = 3'd6;
   localparam logic [2:0] Z3M_RELEASE   = 3'd7;

   localparam logic [1:0] SIZ_LONG  = 2'b00;
   localparam logic [1:0] SIZ_BYTE  = 2'b01;
   localparam logic [1:0] SIZ_WORD  = 2'b10;
   localparam logic [1:0] SIZ_3BYTE = 2'b11;

   function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
      case (siz)
         SIZ_BYTE:  return 3'd1;
         SIZ_WORD:  return 3'd2;
         SIZ_3BYTE: return 3'd3;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/z3_bus_master_if.sv
// rtl/z3_bus_master_if.sv - local request side and Zorro III initiator signals
interface z3_bus_master_if;
   logic       req;
   logic       req_read;
   logic [1:0] req_siz;
   logic [1:0] req_a;
   logic       req_last;
   logic       done;
   logic       berr;
   logic       owner;
   logic       BR_n;
   logic       BG_n;
   logic       BGACK_n;
   logic       ABOE_n;
   logic       FCS_n;
   logic [3:0] DS_n;
   logic       READ_o;
   logic       DOE;
   logic       DTACK_n;
   logic       BERR_n;

   modport master (
      input  req, req_read, req_siz, req_a, req_last, BG_n, DTACK_n, BERR_n,
      output done, berr, owner, BR_n, BGACK_n, ABOE_n, FCS_n, DS_n, READ_o, DOE
   );

   modport slave (
      output req, req_read, req_siz, req_a, req_last, BG_n, DTACK_n, BERR_n,
      input  done, berr, owner, BR_n, BGACK_n, ABOE_n, FCS_n, DS_n, READ_o, DOE
   );
endinterface

// File: rtl/z3_lane_decode.sv
// rtl/z3_lane_decode.sv - SIZ/A1:A0 to active-low byte lane mask, DS_n[3] carries D31:24
module z3_lane_decode
   import z3_bus_master_pkg::*;
(
   input  logic [1:0] siz_i,
   input  logic [1:0] a_i,
   output logic [3:0] ds_n_o
);
   logic [2:0] lo;
   logic [2:0] hi;
   logic [2:0] off;

   // Lane i holds byte offset 3-i; transfers running past offset 3 are clipped.
   always_comb begin
      lo     = {1'b0, a_i};
      hi     = lo + siz_bytes(siz_i);
      ds_n_o = 4'hF;
      off    = 3'd0;
      for (int i = 0; i < 4; i++) begin
         off       = 3'(3 - i);
         ds_n_o[i] = !((off >= lo) && (off < hi));
      end
   end
endmodule

// File: rtl/z3_bus_master.sv
// rtl/z3_bus_master.sv - Zorro III bus-master cycle generator: arbitration, strobes, DTACK/timeout termination
module z3_bus_master
   import z3_bus_master_pkg::*;
#(
   parameter int DTACK_TIMEOUT = 255,
   parameter int ADDR_SETUP    = 1
) (
   input logic             CLK,
   input logic             IORST_n,
   z3_bus_master_if.master bus
);
   logic [1:0] bg_sync_q, dtack_sync_q, berr_sync_q;
   logic       bg_s, dtack_s, berr_s;
   logic [2:0] state_q, state_d;
   logic [1:0] setup_q, setup_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] siz_q, siz_d, a_q, a_d;
   logic       last_q, last_d;
   logic       br_n_q, br_n_d, bgack_n_q, bgack_n_d, aboe_n_q, aboe_n_d, fcs_n_q, fcs_n_d;
   logic [3:0] ds_n_q, ds_n_d, lane_n;
   logic       read_q, read_d, doe_q, doe_d, done_q, done_d, berr_q, berr_d, owner_q, owner_d;

   z3_lane_decode u_lane (.siz_i(siz_q), .a_i(a_q), .ds_n_o(lane_n));

   assign bg_s    = bg_sync_q[1];
   assign dtack_s = dtack_sync_q[1];
   assign berr_s  = berr_sync_q[1];

   always_comb begin
      state_d   = state_q;
      setup_d   = setup_q;
      cnt_d     = cnt_q;
      siz_d     = siz_q;
      a_d       = a_q;
      last_d    = last_q;
      br_n_d    = br_n_q;
      bgack_n_d = bgack_n_q;
      aboe_n_d  = aboe_n_q;
      fcs_n_d   = fcs_n_q;
      ds_n_d    = ds_n_q;
      read_d    = read_q;
      doe_d     = doe_q;
      owner_d   = owner_q;
      done_d    = 1'b0;
      berr_d    = 1'b0;
      case (state_q)
         Z3M_IDLE: begin
            if (bus.req) begin
               br_n_d  = 1'b0;
               state_d = Z3M_REQUEST;
            end
         end
         Z3M_REQUEST: begin
            if (!bus.req) begin
               br_n_d  = 1'b1;
               state_d = Z3M_IDLE;
            end else if (!bg_s && berr_s) begin
               br_n_d    = 1'b1;
               bgack_n_d = 1'b0;
               owner_d   = 1'b1;
               last_d    = 1'b0;
               state_d   = Z3M_OWN;
            end
         end
         Z3M_OWN: begin
            if (bus.req) begin
               siz_d    = bus.req_siz;
               a_d      = bus.req_a;
               last_d   = bus.req_last;
               read_d   = bus.req_read;
               aboe_n_d = 1'b0;
               setup_d  = 2'd1;
               state_d  = Z3M_ADDR;
            end else if (last_q) begin
               bgack_n_d = 1'b1;
               owner_d   = 1'b0;
               aboe_n_d  = 1'b1;
               state_d   = Z3M_RELEASE;
            end
         end
         Z3M_ADDR: begin
            // A DTACK left low by the previous slave must clear before the next FCS.
            if ((setup_q >= 2'(ADDR_SETUP)) && dtack_s) begin
               fcs_n_d = 1'b0;
               doe_d   = 1'b1;
               ds_n_d  = read_q ? lane_n : 4'hF;
               state_d = Z3M_STROBE;
            end else if (setup_q < 2'(ADDR_SETUP)) begin
               setup_d = setup_q + 2'd1;
            end
         end
         Z3M_STROBE: begin
            ds_n_d  = lane_n;
            cnt_d   = 8'd0;
            state_d = Z3M_DATA_WAIT;
         end
         Z3M_DATA_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (!berr_s || (cnt_d == 8'(DTACK_TIMEOUT))) begin
               berr_d  = 1'b1;
               fcs_n_d = 1'b1;
               ds_n_d  = 4'hF;
               doe_d   = 1'b0;
               state_d = Z3M_TERM;
            end else if (!dtack_s) begin
               done_d  = 1'b1;
               fcs_n_d = 1'b1;
               ds_n_d  = 4'hF;
               doe_d   = 1'b0;
               state_d = Z3M_TERM;
            end
         end
         Z3M_TERM: begin
            aboe_n_d = 1'b1;
            read_d   = 1'b0;
            if (last_q || berr_q) begin
               bgack_n_d = 1'b1;
               owner_d   = 1'b0;
               state_d   = Z3M_RELEASE;
            end else begin
               state_d = Z3M_OWN;
            end
         end
         Z3M_RELEASE: state_d = Z3M_IDLE;
         default:     state_d = Z3M_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge IORST_n) begin
      if (!IORST_n) begin
         bg_sync_q    <= 2'b11;
         dtack_sync_q <= 2'b11;
         berr_sync_q  <= 2'b11;
         state_q      <= Z3M_IDLE;
         setup_q      <= 2'd0;
         cnt_q        <= 8'd0;
         siz_q        <= SIZ_LONG;
         a_q          <= 2'd0;
         last_q       <= 1'b0;
         br_n_q       <= 1'b1;
         bgack_n_q    <= 1'b1;
         aboe_n_q     <= 1'b1;
         fcs_n_q      <= 1'b1;
         ds_n_q       <= 4'hF;
         read_q       <= 1'b0;
         doe_q        <= 1'b0;
         done_q       <= 1'b0;
         berr_q       <= 1'b0;
         owner_q      <= 1'b0;
      end else begin
         bg_sync_q    <= {bg_sync_q[0], bus.BG_n};
         dtack_sync_q <= {dtack_sync_q[0], bus.DTACK_n};
         berr_sync_q  <= {berr_sync_q[0], bus.BERR_n};
         state_q      <= state_d;
         setup_q      <= setup_d;
         cnt_q        <= cnt_d;
         siz_q        <= siz_d;
         a_q          <= a_d;
         last_q       <= last_d;
         br_n_q       <= br_n_d;
         bgack_n_q    <= bgack_n_d;
         aboe_n_q     <= aboe_n_d;
         fcs_n_q      <= fcs_n_d;
         ds_n_q       <= ds_n_d;
         read_q       <= read_d;
         doe_q        <= doe_d;
         done_q       <= done_d;
         berr_q       <= berr_d;
         owner_q      <= owner_d;
      end
   end

   assign bus.BR_n    = br_n_q;
   assign bus.BGACK_n = bgack_n_q;
   assign bus.ABOE_n  = aboe_n_q;
   assign bus.FCS_n   = fcs_n_q;
   assign bus.DS_n    = ds_n_q;
   assign bus.READ_o  = read_q;
   assign bus.DOE     = doe_q;
   assign bus.done    = done_q;
   assign bus.berr    = berr_q;
   assign bus.owner   = owner_q;
endmodule

// File: tb/tb_z3_bus_master.sv
// tb/tb_z3_bus_master.sv - directed scoreboard bench for the Zorro III bus master
module tb_z3_bus_master;
   logic CLK = 1'b0;
   logic IORST_n;

   z3_bus_master_if bus ();

   z3_bus_master #(.DTACK_TIMEOUT(255), .ADDR_SETUP(1)) dut (
      .CLK(CLK),
      .IORST_n(IORST_n),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   localparam logic [15:0] IDLE_OUTS = 16'h1FE0;

   int         checks = 0;
   int         errors = 0;
   logic [1:0] exp_q[$];
   int         dtack_delay = -1;
   bit         berr_with_dtack = 1'b0;
   int         br_falls = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [15:0] outs();
      return {3'b000, bus.BR_n, bus.BGACK_n, bus.ABOE_n, bus.FCS_n, bus.DS_n,
              bus.owner, bus.done, bus.berr, bus.DOE, bus.READ_o};
   endfunction

   function automatic bit hit(input int sel);
      case (sel)
         0:       return bus.FCS_n === 1'b0;
         1:       return bus.ABOE_n === 1'b0;
         2:       return bus.DS_n !== 4'hF;
         default: return (bus.done === 1'b1) || (bus.berr === 1'b1);
      endcase
   endfunction

   task automatic wait_hit(input int sel, input int budget, input string tag, output int n);
      n = 0;
      while (!hit(sel) && n < budget) begin
         tick();
         n++;
      end
      check(tag, 16'(hit(sel)), 16'd1);
   endtask

   task automatic acquire(output int br_wait, output int gnt_wait);
      br_wait = 0;
      while (bus.BR_n !== 1'b0 && br_wait < 20) begin
         tick();
         br_wait++;
      end
      repeat (3) tick();
      bus.BG_n = 1'b0;
      gnt_wait = 0;
      while (bus.BGACK_n !== 1'b0 && gnt_wait < 20) begin
         tick();
         gnt_wait++;
      end
      bus.BG_n = 1'b1;
   endtask

   task automatic set_req(input logic rd, input logic [1:0] siz, input logic [1:0] a, input logic last);
      bus.req_read = rd;
      bus.req_siz  = siz;
      bus.req_a    = a;
      bus.req_last = last;
      bus.req      = 1'b1;
   endtask

   // Slave: acknowledges dtack_delay cycles after data strobes appear, releases on FCS_n high.
   initial begin
      int ds_cnt;
      ds_cnt      = 0;
      bus.DTACK_n = 1'b1;
      bus.BERR_n  = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         if (bus.FCS_n === 1'b1) begin
            ds_cnt      = 0;
            bus.DTACK_n = 1'b1;
            bus.BERR_n  = 1'b1;
         end else if (bus.DS_n !== 4'hF) begin
            ds_cnt++;
            if (ds_cnt == dtack_delay) begin
               bus.DTACK_n = 1'b0;
               if (berr_with_dtack) bus.BERR_n = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [1:0] e;
      logic       br_prev;
      br_prev = 1'b1;
      forever begin
         @(negedge CLK);
         if (br_prev === 1'b1 && bus.BR_n === 1'b0) br_falls++;
         br_prev = bus.BR_n;
         if (bus.done === 1'b1 || bus.berr === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 16'({bus.done, bus.berr}), 16'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_result", 16'({bus.done, bus.berr}), 16'(e));
            end
         end
      end
   end

   initial begin
      int   bw, gw, n, gap, bg_breaks, results, aboe_falls;
      logic prev_aboe;
      IORST_n      = 1'b0;
      bus.req      = 1'b0;
      bus.req_read = 1'b0;
      bus.req_siz  = 2'b00;
      bus.req_a    = 2'b00;
      bus.req_last = 1'b0;
      bus.BG_n     = 1'b1;
      repeat (3) tick();
      check("rst_outputs", outs(), IDLE_OUTS);
      IORST_n = 1'b1;
      tick();
      check("idle_hold", outs(), IDLE_OUTS);

      // Read long at 00, grant after 3 cycles, DTACK after 5
      dtack_delay = 5;
      exp_q.push_back(2'b10);
      set_req(1'b1, 2'b00, 2'b00, 1'b1);
      acquire(bw, gw);
      check("t1_br_latency", 16'(bw), 16'd1);
      check("t1_grant_latency", 16'(gw), 16'd3);
      check("t1_own", 16'({bus.owner, bus.BR_n, bus.BGACK_n}), 16'b110);
      wait_hit(1, 10, "t1_aboe", n);
      bus.req = 1'b0;
      check("t1_read_o", 16'(bus.READ_o), 16'd1);
      wait_hit(0, 10, "t1_fcs", n);
      check("t1_strobe", 16'({bus.DOE, bus.DS_n}), 16'b1_0000);
      wait_hit(3, 40, "t1_result", n);
      check("t1_term", 16'({bus.FCS_n, bus.DS_n, bus.DOE, bus.ABOE_n}), 16'b111_1100);
      tick();
      check("t1_release", 16'({bus.owner, bus.BGACK_n, bus.ABOE_n, bus.done}), 16'b0110);
      tick();
      check("t1_idle", outs(), IDLE_OUTS);

      // Write byte at 10
      dtack_delay = 2;
      exp_q.push_back(2'b10);
      set_req(1'b0, 2'b01, 2'b10, 1'b1);
      acquire(bw, gw);
      wait_hit(1, 10, "t2_aboe", n);
      bus.req = 1'b0;
      check("t2_read_o", 16'(bus.READ_o), 16'd0);
      wait_hit(0, 10, "t2_fcs", n);
      check("t2_doe_first", 16'({bus.DOE, bus.DS_n}), 16'b1_1111);
      tick();
      check("t2_ds", 16'({bus.DOE, bus.DS_n}), 16'b1_1101);
      wait_hit(3, 40, "t2_result", n);
      tick();
      tick();
      check("t2_idle", outs(), IDLE_OUTS);

      // Back-to-back: word read (last=0) then long write (last=1)
      br_falls    = 0;
      dtack_delay = 3;
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b10);
      set_req(1'b1, 2'b10, 2'b00, 1'b0);
      acquire(bw, gw);
      gap        = 0;
      bg_breaks  = 0;
      results    = 0;
      aboe_falls = 0;
      prev_aboe  = 1'b1;
      for (int i = 0; i < 200 && results < 2; i++) begin
         tick();
         if (prev_aboe === 1'b1 && bus.ABOE_n === 1'b0) begin
            aboe_falls++;
            if (aboe_falls == 1) set_req(1'b0, 2'b00, 2'b00, 1'b1);
            else bus.req = 1'b0;
         end
         prev_aboe = bus.ABOE_n;
         if (bus.done === 1'b1 || bus.berr === 1'b1) results++;
         else if (bus.BGACK_n !== 1'b0) bg_breaks++;
         if (results == 1 && bus.FCS_n === 1'b1) gap++;
      end
      check("t3_results", 16'(results), 16'd2);
      check("t3_bgack_held", 16'(bg_breaks), 16'd0);
      check("t3_br_once", 16'(br_falls), 16'd1);
      check("t3_fcs_gap", 16'(gap >= 1), 16'd1);
      tick();
      check("t3_release", 16'({bus.owner, bus.BGACK_n}), 16'b01);
      tick();

      // No DTACK: timeout 255 cycles after DATA_WAIT entry; berr forces release with last=0
      dtack_delay = -1;
      exp_q.push_back(2'b01);
      set_req(1'b0, 2'b00, 2'b01, 1'b0);
      acquire(bw, gw);
      wait_hit(1, 10, "t4_aboe", n);
      bus.req = 1'b0;
      wait_hit(2, 10, "t4_ds", n);
      check("t4_lanes", 16'(bus.DS_n), 16'b1000);
      wait_hit(3, 400, "t4_result", n);
      check("t4_timeout_cycles", 16'(n), 16'd255);
      check("t4_term", 16'({bus.berr, bus.done, bus.FCS_n}), 16'b101);
      tick();
      check("t4_release", 16'({bus.owner, bus.BGACK_n, bus.ABOE_n}), 16'b011);
      tick();

      // BERR_n and DTACK_n together: berr wins
      dtack_delay     = 2;
      berr_with_dtack = 1'b1;
      exp_q.push_back(2'b01);
      set_req(1'b1, 2'b01, 2'b11, 1'b1);
      acquire(bw, gw);
      wait_hit(1, 10, "t5_aboe", n);
      bus.req = 1'b0;
      wait_hit(0, 10, "t5_fcs", n);
      check("t5_lanes", 16'(bus.DS_n), 16'b1110);
      wait_hit(3, 40, "t5_result", n);
      check("t5_berr_prio", 16'({bus.done, bus.berr}), 16'b01);
      tick();
      tick();
      berr_with_dtack = 1'b0;
      check("t5_idle", outs(), IDLE_OUTS);

      // Asynchronous reset in DATA_WAIT
      dtack_delay = -1;
      set_req(1'b1, 2'b00, 2'b00, 1'b1);
      acquire(bw, gw);
      wait_hit(1, 10, "t6_aboe", n);
      bus.req = 1'b0;
      wait_hit(0, 10, "t6_fcs", n);
      repeat (3) tick();
      check("t6_in_cycle", 16'({bus.FCS_n, bus.BGACK_n}), 16'b00);
      #3;
      IORST_n = 1'b0;
      #1;
      check("t6_async_reset", outs(), IDLE_OUTS);
      tick();
      tick();
      IORST_n = 1'b1;
      tick();
      check("t6_post_idle", outs(), IDLE_OUTS);
      bus.req = 1'b1;
      tick();
      check("t6_idle_to_req", 16'(bus.BR_n), 16'd0);
      bus.req = 1'b0;
      tick();
      check("t6_req_abort", 16'(bus.BR_n), 16'd1);
      tick();
      check("t6_final_idle", outs(), IDLE_OUTS);

      check("sb_drained", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
